// File: rtl/trace_scheduler_pkg.sv
// trace_scheduler_pkg
//   Shared types and default sizes for the trace scheduler slice.
//   state_e       : scheduler FSM encoding (IDLE/ISSUE/WAIT/WRITE/DONE)
//   *_DEF         : default column count, column width and height width
package trace_scheduler_pkg;

  localparam int NUM_COLS_DEF = 640;
  localparam int COL_W_DEF    = 10;
  localparam int HEIGHT_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/trace_scheduler_if.sv
// trace_scheduler_if
//   Bundles the scheduler's frame timing input, renderer read address,
//   trace buffer write port and tracer handshake.
//   master : scheduler side (drives buffer port and tracer start/column)
//   slave  : environment side (vga_sync/renderer, tracer, trace_buffer)
interface trace_scheduler_if #(
  parameter int COL_W    = 10,
  parameter int HEIGHT_W = 8
);

  logic                vblank;
  logic [COL_W-1:0]    rd_addr;
  logic [COL_W-1:0]    buf_addr;
  logic                buf_we;
  logic [HEIGHT_W-1:0] buf_wdata;
  logic                trace_start;
  logic [COL_W-1:0]    trace_col;
  logic                trace_done;
  logic [HEIGHT_W-1:0] trace_height;

  modport master (
    input  vblank, rd_addr, trace_done, trace_height,
    output buf_addr, buf_we, buf_wdata, trace_start, trace_col
  );

  modport slave (
    output vblank, rd_addr, trace_done, trace_height,
    input  buf_addr, buf_we, buf_wdata, trace_start, trace_col
  );

endinterface

// File: rtl/trace_scheduler_timeout.sv
// trace_timeout
//   Per-column wait counter for the trace scheduler.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : load 1 (the value seen in the first WAIT cycle)
//   enable     : count up, holding once expired
//   expired    : count has reached TIMEOUT_CYCLES
module trace_timeout #(
  parameter int TIMEOUT_CYCLES = 63
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Loading 1 makes the count equal the number of WAIT cycles spent so far,
  // so expiry lands on the TIMEOUT_CYCLES-th WAIT cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_W'(1);
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trace_scheduler.sv
// trace_scheduler
//   Runs the column tracer over columns 0..NUM_COLS-1 once per vblank and
//   writes each returned height into the trace buffer. Outside a pass the
//   buffer address follows the renderer's read address.
//   clk, reset  : system clock, synchronous active-high reset
//   bus         : trace_scheduler_if.master (vblank, rd_addr, buffer port,
//                 tracer start/column/done/height)
//   busy        : FSM not in IDLE
//   frame_done  : 1-cycle pulse after the last column is written
//   overrun     : sticky, last pass aborted by vblank falling
//   timeouts    : saturating count of timed-out columns in current/last pass
//   Build option TRACE_SCHED_CLAMP_EN: clamp latched heights to MAX_HEIGHT.
//
//   state | meaning
//   IDLE  | waiting for vblank rise; buffer address owned by renderer
//   ISSUE | trace_start pulse for trace_col, wait counter loaded
//   WAIT  | waiting for trace_done or timeout
//   WRITE | writing latched height to buffer[trace_col]
//   DONE  | frame_done pulse
module trace_scheduler
  import trace_scheduler_pkg::*;
#(
  parameter int NUM_COLS       = NUM_COLS_DEF,
  parameter int COL_W          = COL_W_DEF,
  parameter int HEIGHT_W       = HEIGHT_W_DEF,
  parameter int TIMEOUT_CYCLES = 63,
  parameter int DEFAULT_HEIGHT = 0,
  parameter int MAX_HEIGHT     = 240
) (
  input  logic                 clk,
  input  logic                 reset,
  trace_scheduler_if.master    bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun,
  output logic [COL_W-1:0]     timeouts
);

  state_e              state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [COL_W-1:0]    timeouts_q, timeouts_d;
  logic [HEIGHT_W-1:0] height_q, height_d;
  logic [HEIGHT_W-1:0] height_in;
  logic                overrun_q, overrun_d;
  logic                vblank_q;
  logic                rise;
  logic                tmo_clear, tmo_en, tmo_expired;
  logic                start_c, we_c, done_c;

  trace_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .expired (tmo_expired)
  );

  assign rise = bus.vblank & ~vblank_q;

`ifdef TRACE_SCHED_CLAMP_EN
  always_comb begin
    height_in = (bus.trace_height > HEIGHT_W'(MAX_HEIGHT)) ? HEIGHT_W'(MAX_HEIGHT)
                                                           : bus.trace_height;
  end
`else
  logic unused_max_height;
  assign unused_max_height = ^MAX_HEIGHT;
  always_comb begin
    height_in = bus.trace_height;
  end
`endif

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    timeouts_d = timeouts_q;
    height_d   = height_q;
    overrun_d  = overrun_q;
    tmo_clear  = 1'b0;
    tmo_en     = 1'b0;
    start_c    = 1'b0;
    we_c       = 1'b0;
    done_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d    = S_ISSUE;
          col_d      = '0;
          timeouts_d = '0;
          overrun_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        start_c   = 1'b1;
        tmo_clear = 1'b1;
        if (!bus.vblank) begin
          state_d   = S_IDLE;
          overrun_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmo_en = 1'b1;
        if (!bus.vblank) begin
          state_d   = S_IDLE;
          overrun_d = 1'b1;
        end else if (bus.trace_done) begin
          height_d = height_in;
          state_d  = S_WRITE;
        end else if (tmo_expired) begin
          height_d = HEIGHT_W'(DEFAULT_HEIGHT);
          if (timeouts_q != '1) begin
            timeouts_d = timeouts_q + COL_W'(1);
          end
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        // A write racing vblank's fall is dropped so the column keeps last frame's value.
        we_c = bus.vblank;
        if (!bus.vblank) begin
          state_d   = S_IDLE;
          overrun_d = 1'b1;
        end else if (col_q == COL_W'(NUM_COLS - 1)) begin
          state_d = S_DONE;
        end else begin
          col_d   = col_q + COL_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      timeouts_q <= '0;
      height_q   <= '0;
      overrun_q  <= 1'b0;
      vblank_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      timeouts_q <= timeouts_d;
      height_q   <= height_d;
      overrun_q  <= overrun_d;
      vblank_q   <= bus.vblank;
    end
  end

  // Pulses are masked during reset so an abandoned pass leaves no write behind.
  assign busy            = (state_q != S_IDLE);
  assign bus.trace_start = start_c & ~reset;
  assign bus.buf_we      = we_c & ~reset;
  assign frame_done      = done_c & ~reset;
  assign bus.trace_col   = col_q;
  assign bus.buf_addr    = busy ? col_q : bus.rd_addr;
  assign bus.buf_wdata   = height_q;
  assign overrun         = overrun_q;
  assign timeouts        = timeouts_q;

endmodule
